// File: rtl/adc_pkg.sv
// Shared state type and sizing helpers for the multi-channel serial ADC sampler.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_t;

    function automatic int frame_len(input int lead, input int dw);
        return lead + dw;
    endfunction

    function automatic int chan_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/adc_chan_rx.sv
// One ADC channel: serial shifter, optional averaging accumulator, result register.
module adc_chan_rx
    import adc_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_sample_en,
    input  logic              i_frame_done,
    input  logic              i_batch_done,
    input  logic              i_adc_sd,
    output logic [DATA_W-1:0] o_data
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0] r_shift;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_word;
    logic [ACC_W-1:0]  w_sum;

    // The final data bit is sampled on the same edge that closes the frame.
    assign w_word = {r_shift[DATA_W-2:0], i_adc_sd};
    assign w_sum  = r_acc + ACC_W'(w_word);
    assign o_data = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_acc   <= '0;
        end else begin
            if (i_sample_en) begin
                r_shift <= w_word;
            end
            if (i_batch_done) begin
                r_acc  <= '0;
                r_data <= DATA_W'(w_sum >> AVG_LOG2);
            end else if (i_frame_done) begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: rtl/adc_array_sampler.sv
// N-channel serial ADC front end: shared adc_clk/adc_cs timing engine
// plus one receive shifter/averager per channel.
module adc_array_sampler
    import adc_pkg::*;
#(
    parameter int NUM       = 2,
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int CLK_DIV   = 4,
    parameter int QUIET     = 2,
    parameter int AVG_LOG2  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  single,
    output logic [NUM-1:0]        adc_clk,
    output logic [NUM-1:0]        adc_cs,
    input  logic [NUM-1:0]        adc_sd,
    output logic [NUM*DATA_W-1:0] data,
    output logic [NUM-1:0]        valid,
    output logic                  strobe,
    output logic                  busy
);

    localparam int FRAME       = frame_len(LEAD_BITS, DATA_W);
    localparam int CONV_TICKS  = 2 * FRAME;
    localparam int QUIET_TICKS = 2 * QUIET;
    localparam int MAX_TICKS   = (CONV_TICKS > QUIET_TICKS) ? CONV_TICKS : QUIET_TICKS;
    localparam int TC_W        = $clog2(MAX_TICKS);
    localparam int DIV_W       = $clog2(CLK_DIV);
    localparam int CNT_W       = AVG_LOG2 + 1;
    localparam int BATCH       = 1 << AVG_LOG2;

    adc_state_t       r_state;
    adc_state_t       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [TC_W-1:0]  r_tcnt;
    logic [CNT_W-1:0] r_conv_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_oneshot;
    logic             r_sclk;
    logic             r_cs;
    logic [NUM-1:0]   r_valid;
    logic             r_strobe;

    logic w_tick;
    logic w_start;
    logic w_sample;
    logic w_frame_done;
    logic w_quiet_done;
    logic w_batch_done;

    assign w_tick       = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_start      = (r_state == ST_IDLE) && (enable || single);
    // Odd ticks drive adc_clk 0->1, which is where each bit is captured.
    assign w_sample     = (r_state == ST_CONV) && w_tick && r_tcnt[0];
    assign w_frame_done = (r_state == ST_CONV) && w_tick
                          && (r_tcnt == TC_W'(CONV_TICKS - 1));
    assign w_quiet_done = (r_state == ST_QUIET) && w_tick
                          && (r_tcnt == TC_W'(QUIET_TICKS - 1));
    assign w_cnt_inc    = r_conv_cnt + 1'b1;
    assign w_batch_done = w_frame_done && (w_cnt_inc == CNT_W'(BATCH));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enable || single) w_state_nxt = ST_CONV;
            end
            ST_CONV: begin
                if (w_frame_done) w_state_nxt = ST_QUIET;
            end
            ST_QUIET: begin
                if (w_quiet_done) begin
                    if ((r_conv_cnt != '0) || (enable && !r_oneshot))
                        w_state_nxt = ST_CONV;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_tcnt     <= '0;
            r_conv_cnt <= '0;
            r_oneshot  <= 1'b0;
            r_sclk     <= 1'b1;
            r_cs       <= 1'b1;
            r_valid    <= '0;
            r_strobe   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_batch_done;
            if (w_batch_done) begin
                r_valid <= '1;
            end
            if (r_state == ST_IDLE) begin
                r_div  <= '0;
                r_tcnt <= '0;
                if (w_start) begin
                    r_cs       <= 1'b0;
                    r_conv_cnt <= '0;
                    r_oneshot  <= single & ~enable;
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (r_state == ST_CONV) begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_frame_done) begin
                        r_tcnt     <= '0;
                        r_cs       <= 1'b1;
                        r_conv_cnt <= w_batch_done ? '0 : w_cnt_inc;
                    end
                    if (w_quiet_done) begin
                        r_tcnt <= '0;
                        r_cs   <= (w_state_nxt != ST_CONV);
                    end
                end
            end
        end
    end

    assign adc_clk = {NUM{r_sclk}};
    assign adc_cs  = {NUM{r_cs}};
    assign valid   = r_valid;
    assign strobe  = r_strobe;
    assign busy    = (r_state != ST_IDLE);

    generate
        for (genvar g = 0; g < NUM; g++) begin : g_chan
            adc_chan_rx #(
                .DATA_W   (DATA_W),
                .AVG_LOG2 (AVG_LOG2)
            ) u_rx (
                .clk          (clk),
                .reset        (reset),
                .i_clr        (w_start),
                .i_sample_en  (w_sample),
                .i_frame_done (w_frame_done),
                .i_batch_done (w_batch_done),
                .i_adc_sd     (adc_sd[g]),
                .o_data       (data[chan_lo(g, DATA_W) +: DATA_W])
            );
        end
    endgenerate

endmodule
